// File: rtl/uart_frame_loader_if.sv
// Byte-in / pixel-write-out bundle for uart_frame_loader.
//   rx_data/rx_valid : byte stream from uart_rx (valid is a 1-cycle strobe)
//   wr_en/wr_addr/wr_data : pixel RAM write port (1-cycle pulses)
//   frame_ready/frame_ack : verified-frame handoff to the inference core
//   frame_error : 1-cycle pulse on checksum mismatch or inter-byte timeout
//   busy : loader is mid-frame
// master = byte source / frame consumer side, slave = the loader.
interface uart_frame_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_ready;
  logic              frame_ack;
  logic              frame_error;
  logic              busy;

  modport master (
    output rx_data, rx_valid, frame_ack,
    input  wr_en, wr_addr, wr_data, frame_ready, frame_error, busy
  );

  modport slave (
    input  rx_data, rx_valid, frame_ack,
    output wr_en, wr_addr, wr_data, frame_ready, frame_error, busy
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Assembles one image frame from a UART byte stream:
//   SYNC_BYTE, NUM_PIXELS pixel bytes (raster order), checksum byte
//   (sum of pixels mod 256). Pixels are written to RAM as they arrive;
//   a matching checksum raises frame_ready until frame_ack, a mismatch or
//   an inter-byte timeout pulses frame_error and drops the frame.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : uart_frame_loader_if.slave (rx bytes in, RAM writes and
//           frame status out)
module uart_frame_loader #(
  parameter int          NUM_PIXELS   = 784,
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
  parameter int          TIMEOUT_CLKS = 1_000_000,
  parameter int          TO_W         = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_frame_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, PIXELS, CHECK, DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [7:0]        sum_q;
  logic [TO_W-1:0]   timer_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              ready_q;
  logic              error_q;
  logic              busy_q;

  logic [7:0]        sum_d;
  logic              expire;

  assign sum_d  = sum_q + bus.rx_data;
  // A byte arriving in the expiry cycle wins, so expiry requires silence.
  assign expire = !bus.rx_valid && (timer_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sum_q     <= '0;
      timer_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
            state_q <= PIXELS;
            idx_q   <= '0;
            sum_q   <= '0;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        PIXELS: begin
          if (bus.rx_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            wr_data_q <= bus.rx_data;
            sum_q     <= sum_d;
            timer_q   <= '0;
            // idx_q stops at LAST_IDX so the address never runs past the image
            if (idx_q == LAST_IDX) state_q <= CHECK;
            else                   idx_q   <= idx_q + 1'b1;
          end else if (expire) begin
            error_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        CHECK: begin
          if (bus.rx_valid) begin
            timer_q <= '0;
            busy_q  <= 1'b0;
            if (bus.rx_data == sum_q) begin
              state_q <= DONE;
              ready_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end
          end else if (expire) begin
            error_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          // Incoming bytes are dropped here so the held frame stays intact.
          if (bus.frame_ack) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_ready = ready_q;
  assign bus.frame_error = error_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: stimulus pushes expected RAM
// writes and frame events; a negedge monitor pops and compares them.
module tb_uart_frame_loader;
  localparam int         NP   = 784;
  localparam int         AW   = 10;
  localparam logic [7:0] SYNC = 8'hAA;
  localparam int         TO   = 50;
  localparam int         TOW  = 8;
  localparam int         EV_RDY = 1;
  localparam int         EV_ERR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_loader_if #(.ADDR_W(AW)) bus ();

  uart_frame_loader #(
    .NUM_PIXELS(NP), .ADDR_W(AW), .SYNC_BYTE(SYNC),
    .TIMEOUT_CLKS(TO), .TO_W(TOW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int wr_q[$];   // expected writes, encoded addr*256 + data
  int ev_q[$];   // expected frame events
  logic prev_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so sampling at negedge is stable.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (wr_q.size() == 0) chk("unexpected_wr_en", 1, 0);
      else begin
        int e;
        e = wr_q.pop_front();
        chk("wr_addr", int'(bus.wr_addr), e / 256);
        chk("wr_data", int'(bus.wr_data), e % 256);
      end
    end
    if (bus.frame_error) begin
      if (ev_q.size() == 0) chk("unexpected_frame_error", 1, 0);
      else chk("event_error", EV_ERR, ev_q.pop_front());
    end
    if (bus.frame_ready && !prev_ready) begin
      if (ev_q.size() == 0) chk("unexpected_frame_ready", 1, 0);
      else chk("event_ready", EV_RDY, ev_q.pop_front());
    end
    prev_ready = bus.frame_ready;
  end

  // Called on a negedge; returns on the negedge after the sampling posedge.
  task automatic put(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pixel i = i mod 256. Full frames append a checksum (good or off by one).
  // hold_at/hold_gap insert one idle gap after pixel hold_at.
  task automatic send_frame(input int npix, input bit good, input int gap,
                            input int hold_at, input int hold_gap);
    logic [7:0] sum;
    logic [7:0] px;
    sum = 8'h00;
    put(SYNC);
    chk("busy_after_sync", int'(bus.busy), 1);
    for (int i = 0; i < npix; i++) begin
      px = 8'(i);
      wr_q.push_back(i * 256 + int'(px));
      sum = sum + px;
      put(px);
      if (i == hold_at) idle(hold_gap);
      else if (gap > 0) idle(gap);
    end
    if (npix == NP) begin
      // For i mod 256 over 784 pixels the sum is 8'hF8.
      ev_q.push_back(good ? EV_RDY : EV_ERR);
      put(good ? sum : sum + 8'h01);
    end
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    chk("ready_after_ack", int'(bus.frame_ready), 0);
  endtask

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.frame_ack = 1'b0;
    idle(3);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    chk("rst_wr_data", int'(bus.wr_data), 0);
    chk("rst_ready", int'(bus.frame_ready), 0);
    chk("rst_error", int'(bus.frame_error), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    idle(2);

    // Good frame, one idle cycle between bytes.
    send_frame(NP, 1'b1, 1, -1, 0);
    idle(2);
    chk("t1_ready", int'(bus.frame_ready), 1);
    chk("t1_busy", int'(bus.busy), 0);

    // Bytes while ready are dropped (monitor flags any write); ack releases.
    for (int i = 0; i < 5; i++) put(8'(i * 7 + 1));
    idle(2);
    chk("t4_ready_held", int'(bus.frame_ready), 1);
    ack();

    // Bad checksum: error pulse, no ready, back to IDLE.
    send_frame(NP, 1'b0, 0, -1, 0);
    idle(1);
    chk("t2_ready", int'(bus.frame_ready), 0);
    chk("t2_busy", int'(bus.busy), 0);
    chk("t2_addr_held", int'(bus.wr_addr), NP - 1);

    // Back-to-back frame; byte after pixel 5 lands exactly on timer expiry.
    send_frame(NP, 1'b1, 0, 5, TO - 1);
    idle(1);
    chk("t5_ready", int'(bus.frame_ready), 1);
    ack();

    // Junk before sync, then 10 pixels and silence.
    put(8'h00);
    put(8'h55);
    idle(2);
    chk("t3_busy_idle", int'(bus.busy), 0);
    ev_q.push_back(EV_ERR);
    send_frame(10, 1'b1, 0, -1, 0);
    idle(TO - 1);
    chk("t3_busy_before_expiry", int'(bus.busy), 1);
    idle(1);
    chk("t3_busy_after_expiry", int'(bus.busy), 0);
    idle(3);

    // Reset in the middle of a frame.
    send_frame(400, 1'b1, 0, -1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_wr_en", int'(bus.wr_en), 0);
    chk("t6_wr_addr", int'(bus.wr_addr), 0);
    chk("t6_wr_data", int'(bus.wr_data), 0);
    chk("t6_ready", int'(bus.frame_ready), 0);
    chk("t6_error", int'(bus.frame_error), 0);
    chk("t6_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    idle(1);
    send_frame(NP, 1'b1, 0, -1, 0);
    idle(1);
    chk("t6_ready_fresh", int'(bus.frame_ready), 1);
    ack();
    idle(3);

    chk("writes_left", wr_q.size(), 0);
    chk("events_left", ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
